mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit sitting directly downstream of the register file. It consumes the two read-port values (Out1 → rs_val, Out2 → rt_val) and produces results in dedicated HI/LO registers, as MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO require. It uses one shift-add or shift-subtract step per cycle. The controller sees a busy/done handshake.

Parameters:
WIDTH, 32, operand width and HI/LO width.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-low reset (sampled on rising clk edge while 0).
start  input  1  request a new operation; accepted only in IDLE.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
rs_val  input  WIDTH  operand A (multiplicand / dividend).
rt_val  input  WIDTH  operand B (multiplier / divisor).
hi_we  input  1  MTHI write enable.
lo_we  input  1  MTLO write enable.
wdata  input  WIDTH  MTHI/MTLO data.
hi  output  WIDTH  HI register (MFHI source).
lo  output  WIDTH  LO register (MFLO source).
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when HI/LO have just been updated by an operation.
div_by_zero  output  1  one-cycle pulse alongside done when a divide had rt_val==0.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0. Any in-flight operation is aborted with no done pulse. Reset overrides every other input.
- States: IDLE → CALC → FINISH → IDLE.
- IDLE, start=1 at edge T0:
  - rs_val, rt_val and op are latched.
  - Signed ops convert the latched operands to magnitudes and record the result signs.
  - Iteration counter is set to WIDTH; state → CALC; busy=1 from after T0.
- CALC:
  - One iteration per edge.
  - Multiply: 2·WIDTH-bit shift-add.
  - Divide: restoring shift-subtract.
  - Counter decrements each edge; after WIDTH iterations (edge T0+WIDTH), state → FINISH.
- FINISH, at edge T0+WIDTH+1:
  - Sign correction is applied and hi/lo are written.
  - done=1 for exactly one cycle and busy=0; state → IDLE.
  - Total latency is WIDTH+1 cycles: results are valid in the cycle where done=1.
- Multiply result: {hi,lo} = full 2·WIDTH-bit product. MULT negates the product when operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient is negated when operand signs differ; remainder takes the sign of the dividend (truncating division).
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero:
  - Same latency as a normal divide.
  - hi = latched rs_val, lo = all ones.
  - div_by_zero pulses together with done.
- Handshake rules:
  - start while busy is ignored; the in-flight operation is unaffected.
  - Operand or op changes while busy have no effect.
- hi_we/lo_we:
  - In IDLE without start, hi←wdata and/or lo←wdata at the edge; both may assert together.
  - While busy, writes are dropped.
  - start and hi_we/lo_we in the same IDLE cycle: start wins and the write is dropped.
- hi/lo hold their value at all other times, including during CALC. They are not updated until FINISH.

Optional Feature:
Macro MDU_EARLY_TERM_EN.
- Defined:
  - Multiplies run n iterations, where n = number of significant bits of |rt| (minimum 1). Latency is therefore n+1 cycles: rt=0 or 1 gives 2 cycles, rt=3 gives 3 cycles.
  - Divides are unchanged.
  - Results are identical to the non-early-termination results.
- Undefined: every operation takes exactly WIDTH+1 cycles.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, start at T0 → done=1 at T0+33; hi=0xFFFFFFFE, lo=0x00000001; busy high T0+1..T0+32.
- MULT rs=0xFFFFFFFD (−3) rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21); same signed path, MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV rs=0xFFFFFFF9 (−7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=5 rt=0 → after 33 cycles hi=5, lo=0xFFFFFFFF; div_by_zero and done both 1 for one cycle.
- During DIVU 100/7:
  - start with MULTU 2×2 at cycle 5 is ignored; final hi=2, lo=14.
  - Repeat the divide with rst=0 at cycle 10 → next cycle busy=0, hi=lo=0, done never pulses.
- Register writes and early termination:
  - IDLE, hi_we=1, wdata=0x1234 → hi=0x1234, lo unchanged.
  - hi_we=1 while busy → hi unchanged.
  - With MDU_EARLY_TERM_EN, MULTU 9×3 → done 3 cycles after start, lo=27, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional MDU_EARLY_TERM_EN: multiplies stop after the significant bits of |rt| have been consumed.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes accepted
// CALC   | one multiply/divide iteration per clock, cnt counts down
// FINISH | sign correction, HI/LO update, done pulse
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt, cnt_init;
  logic [IW-1:0]      bit_idx;
  logic               is_div, neg_q, neg_r, b_zero, done_r, dbz_r;
  logic [WIDTH-1:0]   a_mag, b_mag, rs_lat, quo, rem, hi_r, lo_r;
  logic [2*WIDTH-1:0] prod, prod_nxt;

  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;

  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;

  // Signed ops work on magnitudes; the signs are re-applied in FINISH.
  assign neg_a_in = op[0] & rs_val[WIDTH-1];
  assign neg_b_in = op[0] & rt_val[WIDTH-1];
  assign mag_a_in = neg_a_in ? -rs_val : rs_val;
  assign mag_b_in = neg_b_in ? -rt_val : rt_val;

`ifdef MDU_EARLY_TERM_EN
  function automatic logic [CW-1:0] sig_bits(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int i = 1; i < WIDTH; i++) begin
      if (v[i]) n = CW'(i + 1);
    end
    return n;
  endfunction

  assign cnt_init = op[1] ? CW'(WIDTH) : sig_bits(mag_b_in);
`else
  assign cnt_init = CW'(WIDTH);
`endif

  // MSB-first multiply so an early stop needs no final realignment.
  assign bit_idx  = IW'(cnt - CW'(1));
  assign prod_nxt = (prod << 1) + (b_mag[bit_idx] ? {{WIDTH{1'b0}}, a_mag} : '0);

  assign div_sh  = {rem, quo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, b_mag};
  assign div_sub = div_sh[WIDTH-1:0] - b_mag;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      rs_lat <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= neg_a_in ^ neg_b_in;
            neg_r  <= neg_a_in;
            b_zero <= (rt_val == '0);
            a_mag  <= mag_a_in;
            b_mag  <= mag_b_in;
            rs_lat <= rs_val;
            cnt    <= cnt_init;
            prod   <= '0;
            rem    <= '0;
            quo    <= mag_a_in;
          end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            rem <= div_ge ? div_sub : div_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            prod <= prod_nxt;
          end
        end
        FINISH: begin
          done_r <= 1'b1;
          if (is_div) begin
            if (b_zero) begin
              hi_r  <= rs_lat;
              lo_r  <= '1;
              dbz_r <= 1'b1;
            end else begin
              lo_r <= neg_q ? -quo : quo;
              hi_r <= neg_r ? -rem : rem;
            end
          end else begin
            {hi_r, lo_r} <= neg_q ? -prod : prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_r;
  assign lo          = lo_r;
  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule
